// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and transmitter FSMs.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  localparam int DIV_DEFAULT = 234;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous RX-side inputs; flops reset to 1 (line idle).
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver FSM: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Counters and state are kept as named internal signals for logic-analyser probing.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DIV  = DIV_DEFAULT,
  parameter int HALF = DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  logic              rx_s;
  uart_state_t       estado, siguiente_estado;
  logic [CNT_W-1:0]  conta_rx, conta_rx_next;
  logic [3:0]        conta_8, conta_8_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic              parity_err_reg, parity_err_next;
  logic              parity_bad_reg, parity_bad_next;
`endif

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado         <= IDLE;
      conta_rx       <= '0;
      conta_8        <= '0;
      shift_reg      <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
      parity_bad_reg <= 1'b0;
`endif
    end else begin
      estado         <= siguiente_estado;
      conta_rx       <= conta_rx_next;
      conta_8        <= conta_8_next;
      shift_reg      <= shift_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= parity_err_next;
      parity_bad_reg <= parity_bad_next;
`endif
    end
  end

  always_comb begin
    siguiente_estado = estado;
    conta_rx_next    = (conta_rx == DIV_M1) ? '0 : conta_rx + 1'b1;
    conta_8_next     = conta_8;
    shift_next       = shift_reg;
    rx_data_next     = rx_data_reg;
    rx_valid_next    = 1'b0;
    frame_err_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_next  = 1'b0;
    parity_bad_next  = parity_bad_reg;
`endif

    case (estado)
      IDLE: begin
        conta_rx_next = '0;
        conta_8_next  = '0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = 1'b0;
`endif
        if (!rx_s) siguiente_estado = START;
      end

      START: begin
        // Mid-bit re-check rejects glitches shorter than half a bit.
        if (conta_rx == HALF_M1) siguiente_estado = rx_s ? IDLE : DATA;
      end

      DATA: begin
        if (conta_rx == DIV_M1) begin
          shift_next   = {rx_s, shift_reg[7:1]};
          conta_8_next = conta_8 + 4'd1;
          if (conta_8 == 4'd7) begin
`ifdef UART_RX_PARITY_EN
            siguiente_estado = PARITY;
`else
            siguiente_estado = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (conta_rx == DIV_M1) begin
          parity_bad_next  = rx_s ^ (^shift_reg);
          siguiente_estado = STOP;
        end
      end
`endif

      STOP: begin
        if (conta_rx == DIV_M1) begin
          if (rx_s) begin
            siguiente_estado = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad_reg) begin
              parity_err_next = 1'b1;
            end else begin
              rx_data_next  = shift_reg;
              rx_valid_next = 1'b1;
            end
`else
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
`endif
          end else begin
            frame_err_next   = 1'b1;
            siguiente_estado = BREAK;
          end
        end
      end

      BREAK: begin
        // Held-low line must return high before a new start bit is accepted.
        conta_rx_next = '0;
        if (rx_s) siguiente_estado = IDLE;
      end

      default: siguiente_estado = IDLE;
    endcase

    if (siguiente_estado != estado) conta_rx_next = '0;
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (estado != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at DIV=16; honours UART_RX_PARITY_EN.
module tb_uart_rx_fsm;
  import uart_pkg::*;

  localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT   = 169;
  localparam int FRAME = 176;
`else
  localparam int LAT   = 153;
  localparam int FRAME = 160;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  uart_rx_fsm #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Pulse / busy monitor, sampled on the falling edge.
  int   n_valid = 0, n_ferr = 0, n_perr = 0, multi = 0;
  int   last_valid_cyc = -1, last_ferr_cyc = -1, last_perr_cyc = -1;
  int   last_rise = -1, last_fall = -1;
  int   max_rx = 0, max_c8 = 0;
  logic busy_prev = 1'b0;
  int   valid_cyc_q[$];
  logic [7:0] valid_data_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      valid_cyc_q.push_back(cyc);
      valid_data_q.push_back(rx_data);
    end
    if (frame_err) begin n_ferr++; last_ferr_cyc = cyc; end
    if (parity_err) begin n_perr++; last_perr_cyc = cyc; end
    if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) multi++;
    if (busy && !busy_prev) last_rise = cyc;
    if (!busy && busy_prev) last_fall = cyc;
    busy_prev = busy;
    if (int'(dut.conta_rx) > max_rx) max_rx = int'(dut.conta_rx);
    if (int'(dut.conta_8) > max_c8) max_c8 = int'(dut.conta_8);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All drive tasks start and end #1 after a rising edge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int k);
    k = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    send_bit(stop);
  endtask

  int sv_valid, sv_ferr, sv_perr;
  task automatic snap();
    sv_valid = n_valid;
    sv_ferr  = n_ferr;
    sv_perr  = n_perr;
  endtask

  task automatic check_frame(input string tag, input int k, input int nv, input int nf,
                             input int np, input logic [7:0] d);
    int pc;
    check({tag, "_valid_cnt"}, n_valid - sv_valid, nv);
    check({tag, "_ferr_cnt"},  n_ferr - sv_ferr,   nf);
    check({tag, "_perr_cnt"},  n_perr - sv_perr,   np);
    pc = (nv != 0) ? last_valid_cyc : (nf != 0) ? last_ferr_cyc : last_perr_cyc;
    check({tag, "_pulse_cyc"}, pc, k + 2 + LAT);
    check({tag, "_rx_data"}, rx_data, d);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    int k, k2, qs, rel;
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[2] = '{8'h3C, 1'b0, 0, 1, 8'h5A};
    vecs[3] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[4] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[5] = '{8'hC3, 1'b0, 0, 1, 8'h80};
    vecs[6] = '{8'h96, 1'b1, 1, 0, 8'h96};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Table of frames; parity bit always correct for even parity
    for (int i = 0; i < 7; i++) begin
      snap();
      send_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop, k);
      idle(8);
      $display("frame %0d: data=%02h stop=%0b rx_data=%02h valid=%0d ferr=%0d",
               i, vecs[i].data, vecs[i].stop, rx_data, n_valid - sv_valid, n_ferr - sv_ferr);
      check_frame($sformatf("vec%0d", i), k, vecs[i].exp_valid, vecs[i].exp_ferr, 0, vecs[i].exp_data);
      check($sformatf("vec%0d_busy_rise", i), last_rise, k + 3);
      // Good frame: busy drops with the pulse; framing error: after the line returns high
      check($sformatf("vec%0d_busy_fall", i), last_fall,
            (vecs[i].exp_valid != 0) ? k + 2 + LAT : k + FRAME + 3);
    end

    // Back-to-back frames with no idle gap
    snap();
    qs = valid_cyc_q.size();
    send_frame(8'h00, 1'b0, 1'b1, k);
    send_frame(8'hFF, 1'b0, 1'b1, k2);
    idle(8);
    $display("b2b: frames 00,FF pulses=%0d rx_data=%02h", n_valid - sv_valid, rx_data);
    check("b2b_valid_cnt", n_valid - sv_valid, 2);
    check("b2b_first_cyc", valid_cyc_q[qs], k + 2 + LAT);
    check("b2b_spacing", valid_cyc_q[qs+1] - valid_cyc_q[qs], FRAME);
    check("b2b_data0", valid_data_q[qs], 8'h00);
    check("b2b_data1", valid_data_q[qs+1], 8'hFF);

    // 4-cycle low glitch in IDLE
    snap();
    k = cyc;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    $display("glitch: busy_fall=%0d rx_data=%02h", last_fall, rx_data);
    check("glitch_busy_rise", last_rise, k + 3);
    check("glitch_busy_fall", last_fall, k + 11);
    check("glitch_valid_cnt", n_valid - sv_valid, 0);
    check("glitch_ferr_cnt", n_ferr - sv_ferr, 0);
    check("glitch_rx_data", rx_data, 8'hFF);

    // Stop bit 0 with the line held low for 50 more cycles
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, k);
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    $display("break: ferr=%0d state=%0d busy=%0b", n_ferr - sv_ferr, dut.estado, busy);
    check("brk_ferr_cnt", n_ferr - sv_ferr, 1);
    check("brk_ferr_cyc", last_ferr_cyc, k + 2 + LAT);
    check("brk_valid_cnt", n_valid - sv_valid, 0);
    check("brk_state", 32'(dut.estado), 32'(BREAK));
    check("brk_busy", busy, 1'b1);
    rel = cyc;
    idle(30);
    check("brk_released_busy", busy, 1'b0);
    check("brk_no_restart", (last_rise < rel) ? 1 : 0, 1);
    check("brk_ferr_after", n_ferr - sv_ferr, 1);
    check("brk_rx_data", rx_data, 8'hFF);

    // Reset in the middle of DATA
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("mid_busy_before", busy, 1'b1);
    check("mid_state_before", 32'(dut.estado), 32'(DATA));
    rst_n = 1'b0;
    #1;
    $display("reset mid-frame: rx_data=%02h busy=%0b", rx_data, busy);
    check("mid_rx_data", rx_data, 8'h00);
    check("mid_rx_valid", rx_valid, 1'b0);
    check("mid_frame_err", frame_err, 1'b0);
    check("mid_parity_err", parity_err, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_conta_rx", dut.conta_rx, 16'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);
    check("mid_no_pulse", (n_valid - sv_valid) + (n_ferr - sv_ferr) + (n_perr - sv_perr), 0);
    snap();
    send_frame(8'h81, 1'b0, 1'b1, k);
    idle(8);
    $display("after reset: data=81 rx_data=%02h", rx_data);
    check_frame("post_rst", k, 1, 0, 0, 8'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 0 is wrong, 1 is right
    snap();
    send_frame(8'h07, 1'b0, 1'b1, k);
    idle(8);
    $display("parity bad: data=07 perr=%0d rx_data=%02h", n_perr - sv_perr, rx_data);
    check_frame("par_bad", k, 0, 0, 1, 8'h81);
    snap();
    send_frame(8'h07, 1'b1, 1'b1, k);
    idle(8);
    $display("parity good: data=07 rx_data=%02h", rx_data);
    check_frame("par_good", k, 1, 0, 0, 8'h07);
`endif

    check("one_pulse_per_frame", multi, 0);
    check("max_conta_rx", max_rx, DIV - 1);
    check("max_conta_8", max_c8, 8);
    check("parity_err_total", n_perr,
`ifdef UART_RX_PARITY_EN
          1
`else
          0
`endif
    );

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
